// File: rtl/speed_level_ctrl.sv
// Purpose : debounces raw up/down buttons into a saturating speed level 0..6 plus a motor step tick.
// Latency : raw press stable from edge e0 -> speed_level/level_chg update at edge e(DEBOUNCE_CYCLES+2).
// Backpres: none; human-rate button events, nothing can stall, simultaneous up+down cancel out.
//
// Ports:
//   clk          rising-edge system clock
//   rst          asynchronous active-high reset
//   btn_up       raw bouncy up button, asynchronous to clk
//   btn_down     raw bouncy down button, asynchronous to clk
//   speed_level  registered level 0..6, feeds the seven-segment number_in
//   level_chg    one-cycle pulse in the first cycle a new speed_level is visible
//   step_tick    registered one-cycle step enable, period BASE_PERIOD*(7-level), never at level 0
module speed_level_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BASE_PERIOD     = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] speed_level,
    output logic       level_chg,
    output logic       step_tick
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int TICK_W = $clog2(6 * BASE_PERIOD);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_down, btn_up};

    // Identical synchronizer + debouncer + rising-edge detector per button.
    // Bit 0 = up, bit 1 = down.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic            s1;
        logic            s2;
        logic            db;
        logic            db_d;
        logic [DB_W-1:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                db   <= 1'b0;
                db_d <= 1'b0;
                cnt  <= '0;
            end else begin
                s1   <= btn_raw[i];
                s2   <= s1;
                db_d <= db;
                // Any sample agreeing with the debounced state restarts the count,
                // so only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips it.
                if (s2 == db) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DB_W'(1);
                end
            end
        end

        // One pulse per press; releases and holds generate nothing.
        assign press[i] = db & ~db_d;
    end

    logic              up_evt;
    logic              down_evt;
    logic [2:0]        level_nxt;
    logic              level_changing;
    logic [TICK_W-1:0] period_last;
    logic [TICK_W-1:0] tick_cnt;

    assign up_evt   = press[0];
    assign down_evt = press[1];

    // Saturating level update; coincident up and down events cancel.
    always_comb begin
        level_nxt = speed_level;
        if (up_evt && !down_evt && speed_level != 3'd6) begin
            level_nxt = speed_level + 3'd1;
        end else if (down_evt && !up_evt && speed_level != 3'd0) begin
            level_nxt = speed_level - 3'd1;
        end
    end

    assign level_changing = (level_nxt != speed_level);

    // Terminal count of the tick counter for the current level: BASE_PERIOD*(7-n)-1.
    always_comb begin
        period_last = '0;
        case (speed_level)
            3'd1:    period_last = TICK_W'(6 * BASE_PERIOD - 1);
            3'd2:    period_last = TICK_W'(5 * BASE_PERIOD - 1);
            3'd3:    period_last = TICK_W'(4 * BASE_PERIOD - 1);
            3'd4:    period_last = TICK_W'(3 * BASE_PERIOD - 1);
            3'd5:    period_last = TICK_W'(2 * BASE_PERIOD - 1);
            3'd6:    period_last = TICK_W'(BASE_PERIOD - 1);
            default: period_last = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_level <= 3'd0;
            level_chg   <= 1'b0;
        end else begin
            speed_level <= level_nxt;
            level_chg   <= level_changing;
        end
    end

    // A level change restarts the period so the first tick at the new level
    // lands a full period after the change, and no tick from the old level leaks out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (level_changing || speed_level == 3'd0) begin
            tick_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (tick_cnt == period_last) begin
            tick_cnt  <= '0;
            step_tick <= 1'b1;
        end else begin
            tick_cnt  <= tick_cnt + TICK_W'(1);
            step_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_speed_level_ctrl.sv
// Purpose : self-checking bench for speed_level_ctrl with DEBOUNCE_CYCLES=4, BASE_PERIOD=3.
// Latency : outputs compared every cycle, 1 time unit after each rising edge, against a window/timestamp model.
// Backpres: none; stimulus is directed phases followed by a randomized button/reset phase.
module tb_speed_level_ctrl;

    localparam int D = 4;
    localparam int B = 3;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic [2:0] speed_level;
    logic       level_chg;
    logic       step_tick;

    int total = 0;
    int bad   = 0;

    speed_level_ctrl #(.DEBOUNCE_CYCLES(D), .BASE_PERIOD(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .speed_level (speed_level),
        .level_chg   (level_chg),
        .step_tick   (step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Debounced state flips once the last D synchronized samples (raw samples
    // two edges old) all disagree with it. A press is visible as an event one
    // edge after the debounced rise. Ticks land at whole multiples of the
    // period measured from the edge at which the level last changed.
    bit         hist_u[$];
    bit         hist_d[$];
    logic       m_db_u, m_db_d;
    logic       m_rise_u, m_rise_d;
    logic [2:0] m_level;
    logic       m_chg, m_tick;
    int         k;
    int         last_chg;

    function automatic int period_of(input logic [2:0] lvl);
        return B * (7 - int'(lvl));
    endfunction

    function automatic logic window_disagrees(input bit q[$], input logic db);
        int n = q.size();
        for (int j = 2; j <= D + 1; j++) begin
            if (q[n - j] == db) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist_u.delete();
        hist_d.delete();
        for (int j = 0; j < D + 2; j++) begin
            hist_u.push_back(1'b0);
            hist_d.push_back(1'b0);
        end
        m_db_u = 1'b0; m_db_d = 1'b0;
        m_rise_u = 1'b0; m_rise_d = 1'b0;
        m_level = 3'd0; m_chg = 1'b0; m_tick = 1'b0;
        last_chg = k;
    endtask

    task automatic model_edge();
        int   new_level;
        logic nu, nd;
        new_level = int'(m_level);
        if (m_rise_u && !m_rise_d)      new_level = (new_level < 6) ? new_level + 1 : 6;
        else if (m_rise_d && !m_rise_u) new_level = (new_level > 0) ? new_level - 1 : 0;
        k++;
        if (new_level != int'(m_level)) begin
            m_chg    = 1'b1;
            m_tick   = 1'b0;
            last_chg = k;
        end else begin
            m_chg  = 1'b0;
            m_tick = (m_level != 3'd0) && (((k - last_chg) % period_of(m_level)) == 0);
        end
        m_level = 3'(new_level);

        nu = window_disagrees(hist_u, m_db_u) ? ~m_db_u : m_db_u;
        nd = window_disagrees(hist_d, m_db_d) ? ~m_db_d : m_db_d;
        m_rise_u = nu & ~m_db_u;
        m_rise_d = nd & ~m_db_d;
        m_db_u = nu;
        m_db_d = nd;
        hist_u.push_back(btn_up);
        hist_d.push_back(btn_down);
        while (hist_u.size() > D + 3) void'(hist_u.pop_front());
        while (hist_d.size() > D + 3) void'(hist_d.pop_front());
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag);
        total++;
        assert (speed_level === m_level) else begin
            bad++;
            $error("FAIL %s speed_level observed=%0d expected=%0d edge=%0d", tag, speed_level, m_level, k);
        end
        total++;
        assert (level_chg === m_chg) else begin
            bad++;
            $error("FAIL %s level_chg observed=%0b expected=%0b edge=%0d", tag, level_chg, m_chg, k);
        end
        total++;
        assert (step_tick === m_tick) else begin
            bad++;
            $error("FAIL %s step_tick observed=%0b expected=%0b edge=%0d", tag, step_tick, m_tick, k);
        end
    endtask

    task automatic check_level(input string tag, input logic [2:0] want);
        total++;
        assert (speed_level === want) else begin
            bad++;
            $error("FAIL %s speed_level observed=%0d expected=%0d", tag, speed_level, want);
        end
    endtask

    string phase = "reset";

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check(phase);
    endtask

    task automatic press(input logic u, input logic d, input int hold, input int gap);
        btn_up   = u;
        btn_down = d;
        repeat (hold) step();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (gap) step();
    endtask

    // Asserted 1 time unit after an edge; outputs must clear without waiting for a clock.
    task automatic pulse_reset(input int edges);
        rst = 1'b1;
        model_reset();
        #1;
        check({phase, "_async"});
        repeat (edges) step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        k        = 0;
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        model_reset();
        #1;
        check("reset_t0");
        repeat (2) step();
        rst = 1'b0;

        phase = "idle";
        repeat (50) step();
        check_level("idle_level", 3'd0);

        phase = "hold_up";
        press(1'b1, 1'b0, 20, 45);
        check_level("hold_up_level", 3'd1);

        phase = "bounce";
        for (int i = 0; i < 10; i++) begin
            btn_up = (i % 2 == 0);
            step();
        end
        btn_up = 1'b0;
        repeat (8) step();
        press(1'b1, 1'b0, 3, 8);
        check_level("short_pulse_level", 3'd1);
        press(1'b1, 1'b0, 6, 8);
        check_level("clean_press_level", 3'd2);

        phase = "up_sweep";
        for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 6, 9);
        check_level("saturate_top", 3'd6);
        phase = "down_sweep";
        for (int i = 0; i < 8; i++) press(1'b0, 1'b1, 6, 9);
        check_level("saturate_bottom", 3'd0);

        phase = "both";
        press(1'b1, 1'b1, 10, 10);
        check_level("both_level", 3'd0);

        phase = "reset_mid";
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 6, 8);
        check_level("at_level3", 3'd3);
        for (int i = 0; i < 12 && ((k - last_chg) % 12) != 4; i++) step();
        btn_up = 1'b1;
        repeat (3) step();
        pulse_reset(2);
        btn_up = 1'b0;
        check_level("after_reset", 3'd0);
        phase = "post_reset";
        press(1'b1, 1'b0, 7, 25);
        check_level("post_reset_press", 3'd1);

        phase = "random";
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulse_reset(int'($urandom_range(1, 3)));
            end else begin
                btn_up   = 1'($urandom_range(0, 1));
                btn_down = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 9)) step();
            end
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
